fetch_controller: RTL
=====================

# fetch_controller

Wavefront fetch scheduler for the fetch stage. It tracks which of the 40 wavefront slots are active, have no fetch in flight, and have instruction-buffer space, and picks one per request by round-robin. It drives the per-wavefront PC store's read/increment strobe and read id at the instruction-memory handshake, and tags returning fetches as keep or discard after branch recovery.

## Interface
Parameters:
- NUM_WF, 40, number of wavefront slots
- WFID_W, 6, wavefront id width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- wf_dispatch_valid  in  1  new wavefront becomes active
- wf_dispatch_id  in  WFID_W  id of the dispatched wavefront
- wf_halt_valid  in  1  wavefront finished; deactivate it
- wf_halt_id  in  WFID_W  id of the halted wavefront
- recover_valid  in  1  branch recovery; that wavefront's PC is rewritten this cycle
- recover_wfid  in  WFID_W  id of the recovered wavefront
- ibuff_full  in  NUM_WF  per-wavefront instruction buffer full
- fetch_req_valid  out  1  fetch request to instruction memory
- fetch_req_wfid  out  WFID_W  wavefront id of the request
- fetch_req_ready  in  1  memory accepts the request
- fetch_ack_valid  in  1  memory returns an instruction
- fetch_ack_wfid  in  WFID_W  wavefront id of the return
- fetch_ack_keep  out  1  return is current; write it to the instruction buffer
- pc_rd_en  out  1  PC store read-and-increment strobe
- pc_wf_id_rd  out  WFID_W  PC store read id; always equals fetch_req_wfid

## Operation
- State per slot: active, pending (fetch in flight), stale (in-flight fetch predates a recovery). Reset clears all three vectors. Ids >= NUM_WF on any input are ignored.
- Eligible(i) = active[i] & ~pending[i] & ~stale[i] & ~ibuff_full[i].
- Dispatch sets active. Halt clears active. Halt and dispatch on the same id in the same cycle: halt wins. Dispatch of an already-active id: no effect.
- FSM IDLE:
  - Search from rr_ptr upward, wrapping NUM_WF-1 to 0, for the first eligible slot.
  - If one is found: register it into fetch_req_wfid and go to ISSUE.
  - If none is found: stay in IDLE.
- FSM ISSUE:
  - fetch_req_valid = 1 & ~kill.
  - kill = (halt_valid & halt_id == req_wfid) | (recover_valid & recover_wfid == req_wfid). kill is combinational from this cycle's inputs.
  - Handshake is fetch_req_valid & fetch_req_ready. On handshake: pc_rd_en = 1, set pending[req_wfid], rr_ptr <= req_wfid+1 (wrapping to 0 after NUM_WF-1), go to IDLE.
  - On kill: no handshake; go to IDLE; rr_ptr unchanged.
  - Otherwise hold fetch_req_valid and fetch_req_wfid stable. The request is not withdrawn when ibuff_full rises.
- pc_rd_en = 1 only on the handshake cycle; it is 0 in every other cycle.
- Ack:
  - For a pending id: clear pending and stale; fetch_ack_keep = ~stale[id] (combinational).
  - For a non-pending id: fetch_ack_keep = 0; no state change.
- Recover on a pending id sets stale, unless an ack for that id arrives in the same cycle. In that case the ack uses the pre-recover stale value and stale stays 0.
- Recover on a non-pending id: no state change other than the kill rule in ISSUE.

## Timing
- Reset values: fetch_req_valid 0, fetch_req_wfid 0, pc_wf_id_rd 0, pc_rd_en 0, fetch_ack_keep 0, state IDLE, rr_ptr 0.
- Eligibility seen in cycle N gives fetch_req_valid in cycle N+1.
- Peak rate is one handshake every 2 cycles (IDLE, then ISSUE).
- Dispatch in cycle N updates active at the N edge; the earliest request for that slot is in cycle N+2.
- A handshake in cycle N makes the slot ineligible from cycle N+1. An ack in cycle M makes it eligible again from cycle M+1.
- fetch_ack_keep is valid in the same cycle as fetch_ack_valid.
- Reset mid-request drops fetch_req_valid asynchronously and clears all pending and stale bits. Acks arriving after reset return keep = 0.

## Test plan
- Reset, dispatch ids 0, 5 and 39, ready tied to 1, ack each request 3 cycles later -> grant order 0, 5, 39, 0, ...; pc_rd_en is 1 on exactly the handshake cycles; pc_wf_id_rd == fetch_req_wfid in every cycle.
- Id 3 active, ready held 0 for 10 cycles, ibuff_full[3] raised in cycle 4 -> fetch_req_valid stays 1 with wfid 3 for all 10 cycles; handshake in cycle 11; pending[3] then set.
- Id 7 active and fetch pending, recover_wfid 7, then ack for 7 -> fetch_ack_keep 0; the next request for 7 issues 2 cycles after the ack and its ack returns keep 1.
- Id 7 pending; recover 7 and ack 7 in the same cycle -> fetch_ack_keep 1; stale[7] stays 0.
- Request in ISSUE for id 12, halt 12 in the same cycle as ready -> fetch_req_valid 0 that cycle, pc_rd_en 0, slot 12 never requested again.
- Ack for a non-pending id 20 -> fetch_ack_keep 0, no state change. Dispatch id 45 -> ignored.
- Only id 39 active, then dispatch id 0 -> wrap from 39 to 0 observed. Assert rst low during ISSUE -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
//
// Wavefront fetch scheduler for the fetch stage. It tracks, per wavefront slot,
// whether the slot is active, whether a fetch is in flight (pending) and
// whether that in-flight fetch predates a branch recovery (stale). Each
// request goes to one eligible slot, picked round-robin. The block drives the
// PC store read-and-increment strobe on the instruction-memory handshake and
// tags returning fetches as keep or discard.
//
// Handshake: a request transfers in a cycle where fetch_req_valid and
// fetch_req_ready are both 1. Once raised, fetch_req_valid and fetch_req_wfid
// hold stable until that transfer. The only exception is a same-cycle halt or
// recovery of the requested wavefront (kill), which withdraws the request.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   wf_dispatch_*       activate a wavefront slot
//   wf_halt_*           deactivate a wavefront slot
//   recover_*           branch recovery for a wavefront
//   ibuff_full          per-wavefront instruction buffer full
//   fetch_req_*         request channel to instruction memory
//   fetch_ack_valid/wfid  instruction return from memory
//   fetch_ack_keep      return is current; write it to the instruction buffer
//   pc_rd_en            PC store read-and-increment strobe (handshake cycle only)
//   pc_wf_id_rd         PC store read id (always equals fetch_req_wfid)
//   state_dbg           FSM state: 0 = IDLE, 1 = ISSUE
// -----------------------------------------------------------------------------
module fetch_controller #(
   parameter int NUM_WF = 40,
   parameter int WFID_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wf_dispatch_valid,
   input  logic [WFID_W-1:0] wf_dispatch_id,
   input  logic              wf_halt_valid,
   input  logic [WFID_W-1:0] wf_halt_id,
   input  logic              recover_valid,
   input  logic [WFID_W-1:0] recover_wfid,
   input  logic [NUM_WF-1:0] ibuff_full,
   output logic              fetch_req_valid,
   output logic [WFID_W-1:0] fetch_req_wfid,
   input  logic              fetch_req_ready,
   input  logic              fetch_ack_valid,
   input  logic [WFID_W-1:0] fetch_ack_wfid,
   output logic              fetch_ack_keep,
   output logic              pc_rd_en,
   output logic [WFID_W-1:0] pc_wf_id_rd,
   output logic              state_dbg
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   localparam logic [WFID_W-1:0] LAST_ID = WFID_W'(NUM_WF - 1);

   state_t              state, state_nx;
   logic [WFID_W-1:0]   rr_ptr, rr_nx;
   logic [WFID_W-1:0]   req_wfid_nx;

   logic [NUM_WF-1:0]   active, active_nx;
   logic [NUM_WF-1:0]   pending, pending_nx;
   logic [NUM_WF-1:0]   stale, stale_nx;
   logic [NUM_WF-1:0]   eligible;

   logic                disp_ok, halt_ok, rec_ok, ack_ok;
   logic                ack_hit;
   logic                kill;
   logic                handshake;

   logic                found;
   logic [WFID_W-1:0]   pick;
   int                  cand;
   logic [WFID_W-1:0]   cand_id;

   // Ids outside the slot range are ignored on every input.
   function automatic logic id_in_range(input logic [WFID_W-1:0] id);
      return 32'(id) < NUM_WF;
   endfunction

   assign disp_ok = wf_dispatch_valid & id_in_range(wf_dispatch_id);
   assign halt_ok = wf_halt_valid     & id_in_range(wf_halt_id);
   assign rec_ok  = recover_valid     & id_in_range(recover_wfid);
   assign ack_ok  = fetch_ack_valid   & id_in_range(fetch_ack_wfid);

   // An ack only counts when that slot really has a fetch in flight.
   assign ack_hit        = ack_ok & pending[fetch_ack_wfid];
   // Keep uses the stale bit as it stood before this cycle's recovery.
   assign fetch_ack_keep = ack_hit & ~stale[fetch_ack_wfid];

   assign eligible    = active & ~pending & ~stale & ~ibuff_full;
   assign pc_wf_id_rd = fetch_req_wfid;
   assign state_dbg   = state;

   // -------------------------------------------------------------------------
   // Round-robin search: first eligible slot at or above rr_ptr, wrapping
   // from NUM_WF-1 back to 0.
   // -------------------------------------------------------------------------
   always_comb begin
      found   = 1'b0;
      pick    = '0;
      cand    = 0;
      cand_id = '0;
      for (int i = 0; i < NUM_WF; i++) begin
         cand = int'(rr_ptr) + i;
         if (cand >= NUM_WF) begin
            cand = cand - NUM_WF;
         end
         cand_id = cand[WFID_W-1:0];
         if (!found && eligible[cand_id]) begin
            found = 1'b1;
            pick  = cand_id;
         end
      end
   end

   // -------------------------------------------------------------------------
   // FSM next-state and outputs
   // -------------------------------------------------------------------------
   always_comb begin
      state_nx        = state;
      rr_nx           = rr_ptr;
      req_wfid_nx     = fetch_req_wfid;
      kill            = 1'b0;
      fetch_req_valid = 1'b0;
      handshake       = 1'b0;
      pc_rd_en        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (found) begin
               req_wfid_nx = pick;
               state_nx    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // A halt or recovery of the requested wavefront in this cycle
            // would fetch from a dead or about-to-be-rewritten PC.
            kill = (wf_halt_valid & (wf_halt_id == fetch_req_wfid)) |
                   (recover_valid & (recover_wfid == fetch_req_wfid));
            fetch_req_valid = ~kill;
            handshake       = fetch_req_valid & fetch_req_ready;
            if (handshake) begin
               pc_rd_en = 1'b1;
               rr_nx    = (fetch_req_wfid == LAST_ID) ? '0 : fetch_req_wfid + 1'b1;
               state_nx = ST_IDLE;
            end else if (kill) begin
               state_nx = ST_IDLE;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Per-slot state vectors
   // -------------------------------------------------------------------------
   always_comb begin
      active_nx  = active;
      pending_nx = pending;
      stale_nx   = stale;

      // Halt is applied after dispatch so it wins on a same-id collision.
      if (disp_ok) begin
         active_nx[wf_dispatch_id] = 1'b1;
      end
      if (halt_ok) begin
         active_nx[wf_halt_id] = 1'b0;
      end

      if (handshake) begin
         pending_nx[fetch_req_wfid] = 1'b1;
      end
      if (ack_hit) begin
         pending_nx[fetch_ack_wfid] = 1'b0;
         stale_nx[fetch_ack_wfid]   = 1'b0;
      end
      // A recovery marks the in-flight fetch stale, unless that fetch is
      // returning in this same cycle (it already left with the old stale bit).
      if (rec_ok && pending[recover_wfid] &&
          !(ack_hit && (fetch_ack_wfid == recover_wfid))) begin
         stale_nx[recover_wfid] = 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= ST_IDLE;
         rr_ptr         <= '0;
         fetch_req_wfid <= '0;
         active         <= '0;
         pending        <= '0;
         stale          <= '0;
      end else begin
         state          <= state_nx;
         rr_ptr         <= rr_nx;
         fetch_req_wfid <= req_wfid_nx;
         active         <= active_nx;
         pending        <= pending_nx;
         stale          <= stale_nx;
      end
   end

endmodule
